alu_cmd_issuer: RTL and testbench

- Initiator/sequencer for the team's combinational 32-bit ALU (3-bit opcode, operands A/B, single result).
- Accepts commands over a valid/ready interface and buffers them in a FIFO.
- Drives the ALU operand/opcode inputs one command at a time, samples the ALU result, and returns it over a valid/ready response interface.
- Supports chaining: the previous result can be used as operand A.

---
 rtl/alu_cmd_issuer.sv | 177 +++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: command sequencer for the combinational ALU.
// Buffers commands in a small FIFO, presents one command at a time on
// registered ALU inputs, holds them for ALU_LAT cycles, captures the
// result and returns it with the command tag over a valid/ready
// response port. The last captured result forms an accumulator that a
// later command may use in place of its own operand A.
module alu_cmd_issuer #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // command port
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_opcode,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic                     cmd_use_acc,
    input  logic [TAG_W-1:0]         cmd_tag,
    // ALU side
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_opcode,
    input  logic [WIDTH-1:0]         alu_result,
    // response port
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [TAG_W-1:0]         rsp_tag,
    // control / status
    input  logic                     acc_clr,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_FW = $clog2(DEPTH) + 1;
    localparam int CNT_W  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ALU_LAT - 1);

    typedef struct packed {
        logic [2:0]       opcode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             use_acc;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    cmd_t              mem [DEPTH];
    cmd_t              head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_FW-1:0] count;
    logic              push;
    logic              pop;

    state_t            state;
    logic [CNT_W-1:0]  lat_cnt;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  issue_a;
    logic [TAG_W-1:0]  cur_tag;

    // Ready depends on occupancy only, so it never combinationally follows cmd_valid.
    assign cmd_ready  = (count < CNT_FW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign fifo_count = count;
    assign busy       = (state != IDLE) || (count != '0);
    assign head       = mem[rd_ptr];

    // Operand A is resolved at pop time against the current (pre-clear) accumulator.
    assign issue_a    = head.use_acc ? acc : head.a;

    // Pop whenever the sequencer is free to start the next command.
    always_comb begin
        pop = 1'b0;
        unique case (state)
            IDLE:    pop = (count != '0);
            RESP:    pop = rsp_ready && (count != '0);
            default: pop = 1'b0;
        endcase
    end

    // Command storage, written on push.
    // NOTE: the storage array has no reset; only entries between the pointers are ever read, and those were written first.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{cmd_opcode, cmd_a, cmd_b, cmd_use_acc, cmd_tag};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_FW'(1);
                2'b01:   count <= count - CNT_FW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequencer: load ALU inputs, wait ALU_LAT cycles, capture, hand off the response.
    // NOTE: all state here uses non-blocking assignments, so every right-hand side sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            acc        <= '0;
            cur_tag    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_tag    <= '0;
        end else begin
            // A capture later in this block overrides the clear (last assignment wins).
            if (acc_clr) acc <= '0;

            unique case (state)
                IDLE: begin
                    if (pop) begin
                        alu_a      <= issue_a;
                        alu_b      <= head.b;
                        alu_opcode <= head.opcode;
                        cur_tag    <= head.tag;
                        lat_cnt    <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (lat_cnt == LAST_CNT) begin
                        rsp_data  <= alu_result;
                        rsp_tag   <= cur_tag;
                        rsp_valid <= 1'b1;
                        acc       <= alu_result;
                        state     <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (pop) begin
                            alu_a      <= issue_a;
                            alu_b      <= head.b;
                            alu_opcode <= head.opcode;
                            cur_tag    <= head.tag;
                            lat_cnt    <= '0;
                            state      <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: self-checking bench for alu_cmd_issuer.
// A transaction-level model (command queue, one in-flight slot, one
// pending response, accumulator) predicts every output each cycle for
// the ALU_LAT=1 instance; directed literal checks pin the model. A
// second instance with ALU_LAT=3 is driven by an ALU whose output is
// wrong until its inputs have been stable for three cycles.
module tb_alu_cmd_issuer;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int TW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ALU_LAT=1 instance signals
    logic          cmd_valid, cmd_ready, cmd_use_acc, acc_clr, busy;
    logic [2:0]    cmd_opcode, alu_opcode, fifo_count;
    logic [W-1:0]  cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_data;
    logic [TW-1:0] cmd_tag, rsp_tag;
    logic          rsp_valid, rsp_ready;

    // ALU_LAT=3 instance signals
    logic          cmd_valid3, cmd_ready3, cmd_use_acc3, acc_clr3, busy3;
    logic [2:0]    cmd_opcode3, alu_opcode3, fifo_count3;
    logic [W-1:0]  cmd_a3, cmd_b3, alu_a3, alu_b3, alu_result3, rsp_data3;
    logic [TW-1:0] cmd_tag3, rsp_tag3;
    logic          rsp_valid3, rsp_ready3;

    alu_cmd_issuer #(.WIDTH(W), .DEPTH(D), .TAG_W(TW), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .acc_clr(acc_clr), .busy(busy), .fifo_count(fifo_count)
    );

    alu_cmd_issuer #(.WIDTH(W), .DEPTH(D), .TAG_W(TW), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_opcode(cmd_opcode3),
        .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_use_acc(cmd_use_acc3), .cmd_tag(cmd_tag3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_opcode(alu_opcode3), .alu_result(alu_result3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_tag(rsp_tag3),
        .acc_clr(acc_clr3), .busy(busy3), .fifo_count(fifo_count3)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a + 1;
            3'd3:    return a - 1;
            3'd4:    return a;
            3'd5:    return ~a;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Ideal combinational ALU for the ALU_LAT=1 instance.
    always_comb alu_result = alu_f(alu_opcode, alu_a, alu_b);

    // Slow ALU for the ALU_LAT=3 instance: output is inverted until inputs have been stable three cycles.
    logic [W+W+2:0] last3;
    int             age_reg3;
    int             age_now3;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last3    <= '0;
            age_reg3 <= 1;
        end else begin
            age_reg3 <= ({alu_opcode3, alu_a3, alu_b3} == last3) ? age_reg3 + 1 : 1;
            last3    <= {alu_opcode3, alu_a3, alu_b3};
        end
    end
    always_comb begin
        age_now3    = ({alu_opcode3, alu_a3, alu_b3} == last3) ? age_reg3 + 1 : 1;
        alu_result3 = (age_now3 >= 3) ? alu_f(alu_opcode3, alu_a3, alu_b3)
                                      : ~alu_f(alu_opcode3, alu_a3, alu_b3);
    end

    // ---------------- transaction-level model (ALU_LAT=1 instance) ----------------
    typedef struct {
        logic [2:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          ua;
        logic [TW-1:0] tag;
    } cmd_s;

    cmd_s          mq[$];
    logic          m_inflight = 1'b0;
    logic          m_pending  = 1'b0;
    logic [W-1:0]  m_a = '0, m_b = '0, m_acc = '0, m_rd = '0;
    logic [2:0]    m_op = '0;
    logic [TW-1:0] m_tag = '0, m_rt = '0;

    task automatic model_reset();
        mq.delete();
        m_inflight = 1'b0; m_pending = 1'b0;
        m_a = '0; m_b = '0; m_acc = '0; m_rd = '0;
        m_op = '0; m_tag = '0; m_rt = '0;
    endtask

    task automatic model_step();
        logic         cap, hs, free, do_pop, do_push;
        logic [W-1:0] acc_old;
        cmd_s         c;
        acc_old = m_acc;
        cap     = m_inflight;               // one cycle in flight at ALU_LAT=1
        hs      = m_pending && rsp_ready;
        free    = !m_inflight && (!m_pending || hs);
        do_pop  = free && (mq.size() != 0);
        do_push = cmd_valid && (mq.size() < D);
        if (hs) m_pending = 1'b0;
        if (cap) begin
            m_rd       = alu_f(m_op, m_a, m_b);
            m_rt       = m_tag;
            m_acc      = m_rd;
            m_pending  = 1'b1;
            m_inflight = 1'b0;
        end else if (acc_clr) begin
            m_acc = '0;
        end
        if (do_pop) begin
            c          = mq.pop_front();
            m_a        = c.ua ? acc_old : c.a;
            m_b        = c.b;
            m_op       = c.op;
            m_tag      = c.tag;
            m_inflight = 1'b1;
        end
        if (do_push) mq.push_back('{cmd_opcode, cmd_a, cmd_b, cmd_use_acc, cmd_tag});
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Compare every output against the model, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            check("cmp_cmd_ready",  cmd_ready,  mq.size() < D);
            check("cmp_fifo_count", fifo_count, mq.size());
            check("cmp_busy",       busy,       m_inflight || m_pending || (mq.size() != 0));
            check("cmp_rsp_valid",  rsp_valid,  m_pending);
            check("cmp_rsp_data",   rsp_data,   m_rd);
            check("cmp_rsp_tag",    rsp_tag,    m_rt);
            check("cmp_alu_a",      alu_a,      m_a);
            check("cmp_alu_b",      alu_b,      m_b);
            check("cmp_alu_opcode", alu_opcode, m_op);
        end
    end

    // Response monitor for directed checks.
    typedef struct {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
        int            cyc;
    } rsp_s;
    rsp_s mon_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) mon_q.push_back('{rsp_data, rsp_tag, cyc});
        end
    end

    // ---------------- stimulus helpers (called just after a rising edge) ----------------
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ua, input logic [TW-1:0] tag, output int acyc);
        cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_tag = tag;
        cmd_valid  = 1'b1;
        acyc       = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (cmd_ready) acyc = cyc;
            @(posedge clk); #1;
            if (acyc >= 0) break;
        end
        cmd_valid = 1'b0;
        check("send_accepted", acyc >= 0, 1'b1);
    endtask

    task automatic get_rsp(output rsp_s r);
        for (int n = 0; n < 100; n++) begin
            if (mon_q.size() != 0) break;
            @(negedge clk);
        end
        check("rsp_arrived", mon_q.size() != 0, 1'b1);
        if (mon_q.size() != 0) r = mon_q.pop_front();
        else                   r = '{'0, '0, -1};
        @(posedge clk); #1;
    endtask

    task automatic lat3_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ua, input logic [TW-1:0] tag,
                            input logic [W-1:0] exp_a, input logic [W-1:0] exp_data);
        cmd_opcode3 = op; cmd_a3 = a; cmd_b3 = b; cmd_use_acc3 = ua; cmd_tag3 = tag;
        cmd_valid3  = 1'b1;
        @(negedge clk);
        check("l3_accept", cmd_ready3, 1'b1);
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        @(negedge clk);                           // cycle 1: popped at its end
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            check("l3_alu_a_hold",  alu_a3,      exp_a);
            check("l3_alu_op_hold", alu_opcode3, op);
            check("l3_no_early_rsp", rsp_valid3, 1'b0);
        end
        @(negedge clk);                           // cycle 5
        check("l3_rsp_valid", rsp_valid3, 1'b1);
        check("l3_rsp_data",  rsp_data3,  exp_data);
        check("l3_rsp_tag",   rsp_tag3,   tag);
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rsp_s r;
        int   ac, nacc, prev;
        logic took;

        cmd_valid = 0; cmd_opcode = 0; cmd_a = 0; cmd_b = 0; cmd_use_acc = 0; cmd_tag = 0;
        rsp_ready = 1; acc_clr = 0;
        cmd_valid3 = 0; cmd_opcode3 = 0; cmd_a3 = 0; cmd_b3 = 0; cmd_use_acc3 = 0; cmd_tag3 = 0;
        rsp_ready3 = 1; acc_clr3 = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rsp_valid",  rsp_valid,  1'b0);
        check("rst_fifo_count", fifo_count, 3'd0);
        check("rst_busy",       busy,       1'b0);
        check("rst_cmd_ready",  cmd_ready,  1'b1);
        check("rst_alu_a",      alu_a,      32'h0);
        check("rst_alu_opcode", alu_opcode, 3'b000);
        check("rst_rsp_data",   rsp_data,   32'h0);
        check("rst_rsp_tag",    rsp_tag,    4'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD 5+3, tag 7: latency and ALU input values
        mon_q.delete();
        send(3'd0, 32'd5, 32'd3, 1'b0, 4'd7, ac);
        @(negedge clk);
        @(negedge clk);
        check("add_alu_a",  alu_a,      32'd5);
        check("add_alu_b",  alu_b,      32'd3);
        check("add_alu_op", alu_opcode, 3'b000);
        get_rsp(r);
        check("add_latency", r.cyc - ac, 3);
        check("add_data",    r.data,     32'h0000_0008);
        check("add_tag",     r.tag,      4'd7);

        // SUB 3-5 then NOT 0x0000FFFF
        send(3'd1, 32'd3, 32'd5, 1'b0, 4'd1, ac);
        send(3'd5, 32'h0000_FFFF, 32'h0, 1'b0, 4'd2, ac);
        get_rsp(r);
        check("sub_data", r.data, 32'hFFFF_FFFE);
        check("sub_tag",  r.tag,  4'd1);
        get_rsp(r);
        check("not_data", r.data, 32'hFFFF_0000);
        check("not_tag",  r.tag,  4'd2);

        // Chaining through the accumulator, then clear
        send(3'd0, 32'd10, 32'd20, 1'b0, 4'd3, ac);
        get_rsp(r);
        check("chain_add", r.data, 32'd30);
        send(3'd2, 32'd0, 32'd0, 1'b1, 4'd4, ac);
        get_rsp(r);
        check("chain_inc", r.data, 32'd31);
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        send(3'd4, 32'h1234_5678, 32'h0, 1'b1, 4'd5, ac);
        get_rsp(r);
        check("chain_clr_pass", r.data, 32'd0);

        // Backpressure: 8 offered one per cycle with rsp_ready low
        mon_q.delete();
        rsp_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_opcode = 3'd0; cmd_a = 32'(100 + i); cmd_b = 32'(i); cmd_use_acc = 1'b0;
            cmd_tag = TW'(i); cmd_valid = 1'b1;
            @(negedge clk);
            if (cmd_ready) nacc++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted",   nacc,       5);
        check("bp_cmd_ready",  cmd_ready,  1'b0);
        check("bp_fifo_count", fifo_count, 3'd4);
        for (int k = 0; k < 4; k++) begin
            check("bp_rsp_valid_hold", rsp_valid, 1'b1);
            check("bp_rsp_data_hold",  rsp_data,  32'd100);
            check("bp_rsp_tag_hold",   rsp_tag,   4'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            get_rsp(r);
            check("bp_order_data", r.data, 32'(100 + 2 * i));
            check("bp_order_tag",  r.tag,  TW'(i));
            if (i > 0) check("bp_spacing", r.cyc - prev, 2);
            prev = r.cyc;
        end

        // ALU_LAT=3 instance: hold for three cycles, slow ALU must not be sampled early
        lat3_cmd(3'd6, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0, 4'd9, 32'hA5A5_0000, 32'hA5A5_5A5A);
        lat3_cmd(3'd3, 32'h0,         32'h0000_0001, 1'b1, 4'd6, 32'hA5A5_5A5A, 32'hA5A5_5A59);

        // Randomized traffic, checked each cycle by the model
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            took = cmd_valid && cmd_ready;
            @(posedge clk); #1;
            if (!cmd_valid || took) begin
                cmd_valid   = ($urandom_range(0, 2) != 0);
                cmd_opcode  = 3'($urandom_range(0, 7));
                cmd_a       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;
                cmd_b       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
                cmd_use_acc = 1'($urandom_range(0, 1));
                cmd_tag     = TW'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            acc_clr   = ($urandom_range(0, 7) == 0);
        end
        cmd_valid = 1'b0; acc_clr = 1'b0; rsp_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // Reset while issuing with three commands queued
        rsp_ready = 1'b0;
        nacc = 0;
        for (int n = 0; n < 20 && nacc < 5; n++) begin
            cmd_opcode = 3'd0; cmd_a = 32'(n); cmd_b = 32'd1; cmd_use_acc = 1'b0;
            cmd_tag = TW'(n); cmd_valid = 1'b1;
            @(negedge clk);
            if (cmd_ready) nacc++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("rr_filled", nacc, 5);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rr_queued", fifo_count, 3'd3);
        check("rr_busy",   busy,       1'b1);
        rst_n = 1'b0;
        #1;
        check("rr_rsp_valid",  rsp_valid,  1'b0);
        check("rr_fifo_count", fifo_count, 3'd0);
        check("rr_busy_clr",   busy,       1'b0);
        check("rr_alu_a",      alu_a,      32'h0);
        check("rr_alu_b",      alu_b,      32'h0);
        check("rr_alu_opcode", alu_opcode, 3'b000);
        @(posedge clk); #1;
        mon_q.delete();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("rr_no_stale_rsp", mon_q.size(), 0);
        check("rr_idle_valid",   rsp_valid,    1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
